ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute stage of the 5-stage pipelined MIPS.
- Holds the ID/EX pipeline register, which captures decode-stage operands and the control fields alucontrol[2:0] and shift produced by the ALU decoder.
- Applies forwarding, performs the ALU operation, and registers the result into the EX/MEM register.
- Exports E-stage register fields to the hazard unit.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-index width; also the shamt and shift-amount width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall_e  in  1  hold ID/EX contents
- flush_e  in  1  load a bubble into ID/EX
- rd1_d  in  DATA_W  rs register value
- rd2_d  in  DATA_W  rt register value
- signimm_d  in  DATA_W  sign-extended immediate
- rs_d, rt_d, rd_d  in  REG_AW each  register indices
- shamt_d  in  REG_AW  instr[10:6]
- alucontrol_d  in  3  ALU op from decoder
- shift_d  in  1  1 = shift amount from shamt, 0 = from rs value
- alusrc_d  in  1  srcB is immediate
- regdst_d  in  1  write register is rd (else rt)
- regwrite_d, memtoreg_d, memwrite_d  in  1 each  control bits
- forwarda_e, forwardb_e  in  2 each  00 = regfile, 10 = aluout_m, 01 = result_w, 11 = regfile
- result_w  in  DATA_W  WB-stage result
- rs_e, rt_e, writereg_e  out  REG_AW each  to hazard unit
- regwrite_e, memtoreg_e  out  1 each  to hazard unit
- regwrite_m, memtoreg_m, memwrite_m  out  1 each  EX/MEM control
- aluout_m, writedata_m  out  DATA_W each  EX/MEM data
- writereg_m  out  REG_AW  EX/MEM destination
- zero_m  out  1  aluout equals 0

Behaviour:
- Reset: clk and rst only. rst asserted clears every ID/EX and EX/MEM register to 0 immediately, without waiting for a clock edge. All outputs read 0. A zeroed slot is a bubble (regwrite = memwrite = 0).
- ID/EX update priority on each rising edge: rst > flush_e > stall_e > load.
  - flush_e: all ID/EX fields become 0.
  - stall_e (without flush_e): all ID/EX fields hold.
  - Otherwise: the *_d inputs are captured.
- EX/MEM update:
  - Loads every cycle from the combinational E-stage results.
  - When stall_e = 1 and flush_e = 0, EX/MEM loads a bubble: all control bits 0, data fields 0.
- Latency: one instruction enters ID/EX per unstalled cycle. Its result appears on the *_m outputs one cycle later.
- Forwarding, combinational in E:
  - srcA_e = mux(forwarda_e) over rd1_e, aluout_m, result_w.
  - fwdB_e = mux(forwardb_e) over rd2_e, aluout_m, result_w.
  - Code 11 selects the regfile value.
- Operand B: srcB_e = alusrc_e ? signimm_e : fwdB_e.
- writedata_m captures fwdB_e, never the immediate.
- Shift amount: shamt_e when shift_e = 1, else srcA_e[REG_AW-1:0]. The shifted operand is always srcB_e.
- ALU, by alucontrol:
  - 000: AND
  - 001: OR
  - 010: add, wrap-around, no overflow trap
  - 110: subtract A−B, wrap-around
  - 111: signed set-less-than; result is 1 or 0, zero-extended
  - 011: B logical-shift-left by amount
  - 100: B arithmetic-shift-right by amount, sign-filled
  - 101: B logical-shift-right by amount
- Shift amounts are full range 0..31. A shift by 0 passes B unchanged.
- NOP (sll $0,$0,0) produces 0 with regwrite to register 0. It is harmless; no special case.
- writereg_e = regdst_e ? rd_e : rt_e.
- zero_m registers (aluresult == 0).
- Simultaneous flush_e and stall_e: flush wins. ID/EX is cleared and EX/MEM takes the outgoing instruction normally.
- rst asserted mid-stall or mid-flush: everything clears. The first post-reset edge behaves as a normal load.

Decomposition:
- Shared package (mips_pkg):
  - alucontrol encodings: ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SRA, ALU_SRL, ALU_SUB, ALU_SLT.
  - Forward-select codes: FWD_RF, FWD_MEM, FWD_WB.
  - DATA_W and REG_AW defaults.
- One sub-module, alu: combinational srcA/srcB/shamt/alucontrol -> result. The pipeline registers and muxes stay in ex_stage.

Test Plan:
- Reset: rst pulse between clock edges -> all outputs 0 immediately, before the next edge.
- ADD and SLT: rd1=0x7FFFFFFF, rd2=1, alucontrol=010 -> aluout_m=0x80000000 two edges after issue. Then rd1=0xFFFFFFFF, rd2=1, alucontrol=111 -> aluout_m=1.
- Shifts: rd2=0x80000000, shamt=4, shift=1, alucontrol=100 -> 0xF8000000. Then alucontrol=101 -> 0x08000000. Then shift=0, alucontrol=011, rd1=33 (amount 1), rd2=0x3 -> 0x6.
- Forwarding: forwarda=10 with aluout_m=0x10, forwardb=01 with result_w=0x5, alucontrol=110 -> aluout_m=0xB, writedata_m=0x5.
- Immediate store path: alusrc=1, imm=0x4, rd2=0xAB, alucontrol=010 -> writedata_m=0xAB, aluout_m=rd1+4.
- Stall then flush: stall_e=1 for 2 cycles -> ID/EX holds and EX/MEM shows regwrite_m=0 bubbles. Then flush_e and stall_e together -> rs_e=rt_e=0, regwrite_e=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS datapath.
// ALU operation codes, forwarding selects and default widths.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SLL = 3'b011,
        ALU_SRA = 3'b100,
        ALU_SRL = 3'b101,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } ctrl_t;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU for the execute stage.
// Shifts always operate on b; the amount comes in on shamt.
module alu
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [REG_AW-1:0] shamt,
    input  logic [2:0]        alucontrol,
    output logic [DATA_W-1:0] result
);

    // Select the operation for the current alucontrol code
    always_comb begin
        result = '0;
        case (alucontrol)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(DATA_W-1){1'b0}},
                               ($signed(a) < $signed(b))};
            ALU_SLL: result = b << shamt;
            ALU_SRA: result = DATA_W'($signed(b) >>> shamt);
            ALU_SRL: result = b >> shamt;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, forwarding muxes, ALU, EX/MEM register.
// A stalled E slot sends a bubble into EX/MEM; flush beats stall.
module ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_e,
    input  logic              flush_e,
    input  logic [DATA_W-1:0] rd1_d,
    input  logic [DATA_W-1:0] rd2_d,
    input  logic [DATA_W-1:0] signimm_d,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic [REG_AW-1:0] shamt_d,
    input  logic [2:0]        alucontrol_d,
    input  logic              shift_d,
    input  logic              alusrc_d,
    input  logic              regdst_d,
    input  logic              regwrite_d,
    input  logic              memtoreg_d,
    input  logic              memwrite_d,
    input  logic [1:0]        forwarda_e,
    input  logic [1:0]        forwardb_e,
    input  logic [DATA_W-1:0] result_w,
    output logic [REG_AW-1:0] rs_e,
    output logic [REG_AW-1:0] rt_e,
    output logic [REG_AW-1:0] writereg_e,
    output logic              regwrite_e,
    output logic              memtoreg_e,
    output logic              regwrite_m,
    output logic              memtoreg_m,
    output logic              memwrite_m,
    output logic [DATA_W-1:0] aluout_m,
    output logic [DATA_W-1:0] writedata_m,
    output logic [REG_AW-1:0] writereg_m,
    output logic              zero_m
);

    logic [DATA_W-1:0] rd1_e, rd2_e, signimm_e;
    logic [REG_AW-1:0] rd_e, shamt_e;
    logic [2:0]        alucontrol_e;
    logic              shift_e, alusrc_e, regdst_e, memwrite_e;

    logic [DATA_W-1:0] src_a, fwd_b, src_b, alu_result;
    logic [REG_AW-1:0] shift_amt;
    logic              bubble_m;

    // ID/EX register: flush clears, stall holds, otherwise load
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush_e) begin
            rd1_e        <= '0;
            rd2_e        <= '0;
            signimm_e    <= '0;
            rs_e         <= '0;
            rt_e         <= '0;
            rd_e         <= '0;
            shamt_e      <= '0;
            alucontrol_e <= '0;
            shift_e      <= 1'b0;
            alusrc_e     <= 1'b0;
            regdst_e     <= 1'b0;
            regwrite_e   <= 1'b0;
            memtoreg_e   <= 1'b0;
            memwrite_e   <= 1'b0;
        end else if (!stall_e) begin
            rd1_e        <= rd1_d;
            rd2_e        <= rd2_d;
            signimm_e    <= signimm_d;
            rs_e         <= rs_d;
            rt_e         <= rt_d;
            rd_e         <= rd_d;
            shamt_e      <= shamt_d;
            alucontrol_e <= alucontrol_d;
            shift_e      <= shift_d;
            alusrc_e     <= alusrc_d;
            regdst_e     <= regdst_d;
            regwrite_e   <= regwrite_d;
            memtoreg_e   <= memtoreg_d;
            memwrite_e   <= memwrite_d;
        end
    end

    // Forwarding muxes; code 11 falls back to the register file
    always_comb begin
        src_a = rd1_e;
        fwd_b = rd2_e;
        case (forwarda_e)
            FWD_MEM: src_a = aluout_m;
            FWD_WB:  src_a = result_w;
            default: src_a = rd1_e;
        endcase
        case (forwardb_e)
            FWD_MEM: fwd_b = aluout_m;
            FWD_WB:  fwd_b = result_w;
            default: fwd_b = rd2_e;
        endcase
    end

    assign src_b      = alusrc_e ? signimm_e : fwd_b;
    assign shift_amt  = shift_e ? shamt_e : src_a[REG_AW-1:0];
    assign writereg_e = regdst_e ? rd_e : rt_e;
    assign bubble_m   = stall_e && !flush_e;

    alu #(
        .DATA_W(DATA_W),
        .REG_AW(REG_AW)
    ) u_alu (
        .a         (src_a),
        .b         (src_b),
        .shamt     (shift_amt),
        .alucontrol(alucontrol_e),
        .result    (alu_result)
    );

    // EX/MEM register: loads every cycle, bubble while E is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bubble_m) begin
            regwrite_m  <= 1'b0;
            memtoreg_m  <= 1'b0;
            memwrite_m  <= 1'b0;
            aluout_m    <= '0;
            writedata_m <= '0;
            writereg_m  <= '0;
            zero_m      <= 1'b0;
        end else begin
            regwrite_m  <= regwrite_e;
            memtoreg_m  <= memtoreg_e;
            memwrite_m  <= memwrite_e;
            aluout_m    <= alu_result;
            writedata_m <= fwd_b;
            writereg_m  <= writereg_e;
            zero_m      <= (alu_result == '0);
        end
    end

endmodule
